// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC/fetch sequencer: next-PC select encodings
// (also used by the decoder) and the fetch FSM state encoding.
package pc_fetch_pkg;

    localparam logic [1:0] PRS_SEQ = 2'b00;
    localparam logic [1:0] PRS_BR  = 2'b01;
    localparam logic [1:0] PRS_JR  = 2'b10;
    localparam logic [1:0] PRS_J   = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_t;

    // Branch offset: sign-extended word offset, already scaled to bytes.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC and link-value generation, selected by prsource.
module pc_next_calc
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  prsource,
    input  logic [15:0] imm,
    input  logic [25:0] addr26,
    input  logic [31:0] ra_val,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        unique case (prsource)
            PRS_SEQ: next_pc = pc_plus4;
            PRS_BR:  next_pc = pc_plus4 + br_offset(imm);
            PRS_JR:  next_pc = ra_val;
            PRS_J:   next_pc = {pc_plus4[31:28], addr26, 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer (BOOT -> FETCH -> EXEC).
// Optional target alignment check enabled by defining PC_FETCH_ALIGN_CHECK_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  prsource,
    input  logic [15:0] imm,
    input  logic [25:0] addr26,
    input  logic [31:0] ra_val,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        misalign,
    output logic [1:0]  fsm_state
);

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic [31:0]  pc_load;
    logic         target_misaligned;

    pc_next_calc u_next (
        .pc       (pc),
        .prsource (prsource),
        .imm      (imm),
        .addr26   (addr26),
        .ra_val   (ra_val),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

`ifdef PC_FETCH_ALIGN_CHECK_EN
    assign target_misaligned = (next_pc[1:0] != 2'b00);
    assign pc_load           = {next_pc[31:2], 2'b00};
`else
    assign target_misaligned = 1'b0;
    assign pc_load           = next_pc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            instr    <= '0;
            retired  <= '0;
            misalign <= 1'b0;
        end else begin
            unique case (state)
                ST_BOOT: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (advance) begin
                        pc      <= pc_load;
                        retired <= retired + 32'd1;
                        if (target_misaligned) misalign <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    // Decoded from the state register so the request drops with async reset.
    assign imem_req    = (state == ST_FETCH);
    assign instr_valid = (state == ST_EXEC);
    assign imem_addr   = pc;
    assign fsm_state   = state;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed, table-driven bench for pc_fetch with RESET_PC = 0x100.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  prsource = 2'b00;
    logic [15:0] imm = '0;
    logic [25:0] addr26 = '0;
    logic [31:0] ra_val = '0;
    logic        advance = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;
    logic        misalign;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_ret = '0;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prsource    (prsource),
        .imm         (imm),
        .addr26      (addr26),
        .ra_val      (ra_val),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retired     (retired),
        .misalign    (misalign),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  prs;
        logic [15:0] imm;
        logic [25:0] a26;
        logic [31:0] ra;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in FETCH; serves the fetch after `waits` stall cycles.
    task automatic fetch(input logic [31:0] data, input int waits, input logic [31:0] exp_addr);
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_addr);
        check("fetch_ivalid", {31'd0, instr_valid}, 32'd0);
        for (int w = 0; w < waits; w++) begin
            imem_ack = 1'b0;
            advance  = 1'b1;
            @(negedge clk);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, exp_addr);
            check("wait_pc", pc, exp_addr);
        end
        advance    = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        check("exec_ivalid", {31'd0, instr_valid}, 32'd1);
        check("exec_instr", instr, data);
    endtask

    task automatic step(input vec_t v);
        prsource = v.prs;
        imm      = v.imm;
        addr26   = v.a26;
        ra_val   = v.ra;
        advance  = 1'b1;
        @(negedge clk);
        advance  = 1'b0;
        prsource = 2'b10;
        ra_val   = 32'hDEAD_BEE0;
        exp_ret  = exp_ret + 32'd1;
        check("step_pc", pc, v.exp_pc);
        check("step_plus4", pc_plus4, v.exp_pc + 32'd4);
        check("step_retired", retired, exp_ret);
        check("step_misalign", {31'd0, misalign}, {31'd0, v.exp_mis});
    endtask

    logic [31:0] last_pc;
    logic        last_mis;
    vec_t        extra;

    initial begin
        vecs[0]  = '{PRS_SEQ, 16'h0000, 26'h0, 32'h0,          32'hA000_0001, 0, 32'h0000_0104, 1'b0};
        vecs[1]  = '{PRS_SEQ, 16'h0000, 26'h0, 32'h0,          32'hA000_0002, 0, 32'h0000_0108, 1'b0};
        vecs[2]  = '{PRS_JR,  16'h0000, 26'h0, 32'h0000_0200,  32'hA000_0003, 0, 32'h0000_0200, 1'b0};
        vecs[3]  = '{PRS_BR,  16'hFFFF, 26'h0, 32'h0,          32'hA000_0004, 3, 32'h0000_0200, 1'b0};
        vecs[4]  = '{PRS_BR,  16'h0003, 26'h0, 32'h0,          32'hA000_0005, 1, 32'h0000_0210, 1'b0};
        vecs[5]  = '{PRS_JR,  16'h0000, 26'h0, 32'h9000_0040,  32'hA000_0006, 0, 32'h9000_0040, 1'b0};
        vecs[6]  = '{PRS_J,   16'h0000, 26'h0000010, 32'h0,    32'hA000_0007, 0, 32'h9000_0040, 1'b0};
        vecs[7]  = '{PRS_J,   16'h0000, 26'h3FFFFFF, 32'h0,    32'hA000_0008, 2, 32'h9FFF_FFFC, 1'b0};
        vecs[8]  = '{PRS_SEQ, 16'h0000, 26'h0, 32'h0,          32'hA000_0009, 0, 32'hA000_0000, 1'b0};
        vecs[9]  = '{PRS_JR,  16'h0000, 26'h0, 32'hFFFF_FFFC,  32'hA000_000A, 0, 32'hFFFF_FFFC, 1'b0};
        vecs[10] = '{PRS_SEQ, 16'h0000, 26'h0, 32'h0,          32'hA000_000B, 0, 32'h0000_0000, 1'b0};
        vecs[11] = '{PRS_BR,  16'h8000, 26'h0, 32'h0,          32'hA000_000C, 0, 32'hFFFE_0004, 1'b0};
        vecs[12] = '{PRS_JR,  16'h0000, 26'h0, 32'h0000_1234,  32'hA000_000D, 0, 32'h0000_1234, 1'b0};
`ifdef PC_FETCH_ALIGN_CHECK_EN
        vecs[13] = '{PRS_JR,  16'h0000, 26'h0, 32'h0000_1236,  32'hA000_000E, 0, 32'h0000_1234, 1'b1};
`else
        vecs[13] = '{PRS_JR,  16'h0000, 26'h0, 32'h0000_1236,  32'hA000_000E, 0, 32'h0000_1236, 1'b0};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_state", {30'd0, fsm_state}, {30'd0, ST_BOOT});
        check("rst_instr", instr, 32'd0);
        check("rst_retired", retired, 32'd0);
        rst_n = 1'b1;
        #1;
        check("boot_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);

        // Main table: each entry retires the current instruction, then serves the next fetch
        fetch(32'hA000_0000, 0, RST_PC);
        for (int i = 0; i < 14; i++) begin
            step(vecs[i]);
            fetch(vecs[i].rdata, vecs[i].waits, vecs[i].exp_pc);
        end
        last_pc  = vecs[13].exp_pc;
        last_mis = vecs[13].exp_mis;

        // Spurious ack in EXEC leaves the instruction alone
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        imem_ack = 1'b0;
        check("spur_instr", instr, vecs[13].rdata);
        check("spur_ivalid", {31'd0, instr_valid}, 32'd1);

        // misalign is sticky across a later aligned advance
        extra = '{PRS_SEQ, 16'h0, 26'h0, 32'h0, 32'h0, 0, last_pc + 32'd4, last_mis};
        step(extra);

        // Reset asserted mid-FETCH
        imem_ack = 1'b0;
        @(negedge clk);
        check("midf_req_before", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midf_req", {31'd0, imem_req}, 32'd0);
        check("midf_pc", pc, RST_PC);
        check("midf_retired", retired, 32'd0);
        check("midf_ivalid", {31'd0, instr_valid}, 32'd0);
        check("midf_misalign", {31'd0, misalign}, 32'd0);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rerun_req", {31'd0, imem_req}, 32'd1);
        check("rerun_addr", imem_addr, RST_PC);
        check("rerun_instr", instr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch sequencer for the CPU core. It sits upstream of the instruction decoder. It holds the PC and fetches each instruction from instruction memory through a request/acknowledge handshake, then presents the instruction to the decoder. When told to advance, it consumes the decoder's 2-bit next-PC select (`prsource`) and forms the next PC: sequential, branch, register jump or absolute jump.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be word-aligned.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `prsource` in 2: next-PC select from decoder; 00 = PC+4, 01 = branch, 10 = register (jr), 11 = jump/jal.
- `imm` in 16: instruction immediate, used for the branch offset.
- `addr26` in 26: jump target field.
- `ra_val` in 32: rs register value, used as the jr target.
- `advance` in 1: retire the current instruction and apply `prsource`; sampled only in EXEC.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: memory has data on `imem_rdata` this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr` out 32: registered instruction presented to the decoder.
- `instr_valid` out 1: `instr` is valid (EXEC state).
- `pc` out 32: current PC.
- `pc_plus4` out 32: PC+4, combinational; this is the jal link value.
- `retired` out 32: count of retired instructions.
- `misalign` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- FSM has three states:
  - BOOT: one cycle after reset release; `imem_req`=0; goes to FETCH unconditionally.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`, both held stable until ack. On `imem_ack`=1: `instr`<=`imem_rdata`, go to EXEC.
  - EXEC: `instr_valid`=1. On `advance`=1: `pc`<=next_pc, `retired`<=`retired`+1, go to FETCH.
- next_pc by `prsource`:
  - 00: `pc_plus4`.
  - 01: `pc_plus4` + ({{14{imm[15]}}, imm, 2'b00}).
  - 10: `ra_val`.
  - 11: {`pc_plus4`[31:28], `addr26`, 2'b00}.
- All arithmetic is 32-bit modulo 2^32. PC 0xFFFF_FFFC + 4 wraps to 0. `retired` wraps 0xFFFF_FFFF to 0.
- `imem_ack` outside FETCH is ignored. `advance` outside EXEC is ignored. `prsource`, `imm`, `addr26` and `ra_val` are sampled only on the advancing edge.

## Timing
- Reset values: `pc`=`RESET_PC`, state=BOOT, `imem_req`=0, `instr`=0, `instr_valid`=0, `retired`=0, `misalign`=0.
- `imem_req` is a registered-state decode, so it deasserts as soon as `rst_n` falls, including in the middle of a fetch. A pending ack is then dropped.
- Zero-wait memory (ack in the same cycle as req) gives FETCH for 1 cycle, then EXEC. Minimum throughput is 2 cycles per instruction.
- With N wait cycles, FETCH lasts N+1 cycles.
- `pc` updates on the `advance` edge. `imem_addr` shows the new PC in the very next FETCH cycle.
- `pc_plus4` is valid in every state and tracks `pc` combinationally.

## Configuration
- `PC_FETCH_ALIGN_CHECK_EN` defined:
  - If next_pc[1:0]≠0 at advance (only possible with `prsource`=10), `misalign` sets and stays set until reset.
  - The PC loads next_pc with bits [1:0] forced to 00.
- `PC_FETCH_ALIGN_CHECK_EN` undefined:
  - `misalign` is tied to 0.
  - next_pc loads unmodified, so `imem_addr` may be unaligned.

## Structure
- Shared package holds:
  - The `prsource` encodings (PRS_SEQ=2'b00, PRS_BR=2'b01, PRS_JR=2'b10, PRS_J=2'b11), also used by the decoder.
  - The FSM state encoding (BOOT, FETCH, EXEC).
- One sub-module, `pc_next_calc`: purely combinational next_pc and `pc_plus4` generation, so the target math can be tested in isolation. The FSM, registers and counter stay in `pc_fetch`.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory: `imem_req` rises 1 cycle after reset release with `imem_addr`=0x100. With `advance` held at 1 and `prsource`=00, `pc` steps 0x104, 0x108, one instruction every 2 cycles, and `retired` increments each time.
- Branch at pc=0x200 with imm=0xFFFF, prsource=01: next `imem_addr`=0x200. With imm=0x0003: next `imem_addr`=0x210.
- Jump at pc=0x9000_0040 with addr26=0x0000010, prsource=11: next `imem_addr`=0x9000_0040. A jr with ra_val=0x1234 loads `pc`=0x1234.
- Memory with 3 wait cycles: `imem_req` and `imem_addr` stay stable for 4 cycles. An `advance` pulse during FETCH is ignored. A spurious `imem_ack` in EXEC does not change `instr`.
- `rst_n` asserted mid-FETCH: `imem_req` drops in the same cycle, and `pc`, `retired` and `instr_valid` return to reset values.
- With `PC_FETCH_ALIGN_CHECK_EN` defined, jr with ra_val=0x1236: `pc`=0x1234 and `misalign`=1 until reset. With the macro undefined: `pc`=0x1236 and `misalign`=0.
